dummy_accelerator_ctl: RTL and testbench
========================================

// Module: dummy_accelerator_ctl
// PURPOSE
// - X-IF sequencer for the dummy accelerator datapath: decodes offloaded instructions, waits for
//   commit/kill, dispatches ctl+operands+tag to the datapath, returns its result on the X-IF result bus.
// - Single instruction in flight; sits between the core's X-IF and the accelerator datapath.
// PARAMETERS (package-level constants)
// - XLEN        32   operand/result width
// - X_ID_WIDTH  4    X-IF instruction id width
// - X_NUM_RS    2    source registers read
// - IMM_WIDTH   12   ctl word width (instr[31:20])
// - ADDR_WIDTH  5    rd index width; TAG_W = X_ID_WIDTH+ADDR_WIDTH = 9 ({id, rd_idx})
// PORTS
// - clk_i               in   1              clock
// - rst_i               in   1              reset, synchronous, active-high
// - x_issue_valid_i     in   1              issue request
// - x_issue_ready_o     out  1              issue handshake ready
// - x_issue_instr_i     in   32             instruction word
// - x_issue_id_i        in   X_ID_WIDTH     instruction id
// - x_issue_rs_i        in   X_NUM_RS*XLEN  {rs2, rs1}
// - x_issue_rs_valid_i  in   X_NUM_RS       operand valid flags
// - x_issue_accept_o    out  1              instruction accepted (qualified by handshake)
// - x_issue_writeback_o out  1              accepted instr will write rd (= accept)
// - x_commit_valid_i    in   1              commit strobe
// - x_commit_id_i       in   X_ID_WIDTH     id being committed
// - x_commit_kill_i     in   1              1 = kill, 0 = commit
// - acc_valid_o/acc_ready_i out/in 1        datapath request handshake
// - acc_ctl_o           out  IMM_WIDTH      ctl word
// - acc_op_a_o/acc_op_b_o out XLEN          rs1 / rs2
// - acc_tag_o           out  TAG_W          {id, rd_idx}
// - acc_res_valid_i/acc_res_ready_o in/out 1 datapath response handshake
// - acc_res_data_i      in   XLEN           result; acc_res_tag_i in TAG_W returned tag
// - x_result_valid_o/x_result_ready_i out/in 1 X-IF result handshake
// - x_result_id_o       out  X_ID_WIDTH;  x_result_rd_o out ADDR_WIDTH;  x_result_data_o out XLEN
// - x_result_we_o       out  1              write enable (rd_idx != 0)
// - busy_o              out  1              state != IDLE
// BEHAVIOUR
// - Reset (sync): state=IDLE; all valid/ready/accept/we/busy outputs 0 except x_issue_ready_o per
//   IDLE rule; data/tag registers 0. Reset mid-op aborts at next edge; pending datapath response
//   is not consumed (acc_res_ready_o=0 in IDLE).
// - match = instr[6:0]==7'b1110111 && instr[14:12]==3'b000.
// - IDLE: x_issue_ready_o = !match | &x_issue_rs_valid_i; accept_o = match. Handshake with match:
//   latch id, rd=instr[11:7], ctl=instr[31:20], rs1, rs2 -> WAIT_COMMIT. Non-match: rejected, stay.
// - Same-cycle commit for the issuing id at handshake: kill -> stay IDLE; commit -> EXEC directly.
// - WAIT_COMMIT: commit_valid && commit_id==latched id: kill -> IDLE, else -> EXEC. Other ids ignored.
// - EXEC: acc_valid_o=1, payload stable until acc_ready_i -> WAIT_RES.
// - WAIT_RES: acc_res_ready_o=1; on acc_res_valid_i latch data+tag -> RESULT.
// - RESULT: x_result_valid_o=1, fields from latched tag/data, stable until x_result_ready_i -> IDLE.
// - ready_o=0 in all non-IDLE states. Min latency: issue+commit cycle N -> acc_valid N+1;
//   response handshake cycle M -> x_result_valid M+1; next issue accepted cycle after result handshake.
// CONFIGURATION
// - DUMMY_ACC_CTL_PERF_EN defined: adds perf_accepted_o, perf_killed_o (32b out), incremented on
//   accepted issue / kill respectively, wrap 0xFFFFFFFF->0, cleared by rst_i.
// - Undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - instr 0x0012_8077 (rd=0, ctl=1), id=3, rs=5/7; commit id3 next cycle -> acc_valid with
//   ctl=1, op_a=5, op_b=7, tag={3,0}; result 12 -> x_result id=3, data=12, we=0.
// - Non-match instr 0x0000_0033 in IDLE -> ready=1, accept=0, state stays IDLE, busy=0.
// - Accept id=5, commit id=2 then kill id=5 -> no acc_valid, back to IDLE, next issue accepted.
// - Issue+commit id=1 same cycle -> acc_valid next cycle; hold acc_ready=0 3 cycles -> payload stable.
// - x_result_ready_i low 4 cycles -> result held, issue_ready_o=0; rst_i mid-WAIT_RES -> IDLE, outputs 0.
// - PERF_EN: 3 accepts, 1 kill -> perf_accepted_o=3, perf_killed_o=1.

Source files
------------

// File: rtl/dummy_accelerator_ctl_if.sv
// Purpose : bundle of the X-IF (issue/commit/result) and accelerator
//           datapath (request/response) signals of dummy_accelerator_ctl.
// Modports: slave  - the controller's view (consumes issue/commit, drives
//                    the datapath request and the X-IF result)
//           master - the environment's view (core + datapath side)
// Signals : x_issue_*  issue request, instruction, id, operands, accept
//           x_commit_* commit/kill strobe for an id
//           acc_*      datapath request (ctl, operands, tag) and response
//           x_result_* result returned to the core
interface dummy_accelerator_ctl_if;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned X_ID_WIDTH = 4;
    localparam int unsigned X_NUM_RS   = 2;
    localparam int unsigned IMM_WIDTH  = 12;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned TAG_W      = X_ID_WIDTH + ADDR_WIDTH;

    logic                       x_issue_valid_i;
    logic                       x_issue_ready_o;
    logic [31:0]                x_issue_instr_i;
    logic [X_ID_WIDTH-1:0]      x_issue_id_i;
    logic [X_NUM_RS*XLEN-1:0]   x_issue_rs_i;
    logic [X_NUM_RS-1:0]        x_issue_rs_valid_i;
    logic                       x_issue_accept_o;
    logic                       x_issue_writeback_o;

    logic                       x_commit_valid_i;
    logic [X_ID_WIDTH-1:0]      x_commit_id_i;
    logic                       x_commit_kill_i;

    logic                       acc_valid_o;
    logic                       acc_ready_i;
    logic [IMM_WIDTH-1:0]       acc_ctl_o;
    logic [XLEN-1:0]            acc_op_a_o;
    logic [XLEN-1:0]            acc_op_b_o;
    logic [TAG_W-1:0]           acc_tag_o;

    logic                       acc_res_valid_i;
    logic                       acc_res_ready_o;
    logic [XLEN-1:0]            acc_res_data_i;
    logic [TAG_W-1:0]           acc_res_tag_i;

    logic                       x_result_valid_o;
    logic                       x_result_ready_i;
    logic [X_ID_WIDTH-1:0]      x_result_id_o;
    logic [ADDR_WIDTH-1:0]      x_result_rd_o;
    logic [XLEN-1:0]            x_result_data_o;
    logic                       x_result_we_o;

    logic                       busy_o;

    modport slave (
        input  x_issue_valid_i, x_issue_instr_i, x_issue_id_i, x_issue_rs_i,
               x_issue_rs_valid_i,
        output x_issue_ready_o, x_issue_accept_o, x_issue_writeback_o,
        input  x_commit_valid_i, x_commit_id_i, x_commit_kill_i,
        output acc_valid_o, acc_ctl_o, acc_op_a_o, acc_op_b_o, acc_tag_o,
        input  acc_ready_i,
        input  acc_res_valid_i, acc_res_data_i, acc_res_tag_i,
        output acc_res_ready_o,
        output x_result_valid_o, x_result_id_o, x_result_rd_o, x_result_data_o,
               x_result_we_o,
        input  x_result_ready_i,
        output busy_o
    );

    modport master (
        output x_issue_valid_i, x_issue_instr_i, x_issue_id_i, x_issue_rs_i,
               x_issue_rs_valid_i,
        input  x_issue_ready_o, x_issue_accept_o, x_issue_writeback_o,
        output x_commit_valid_i, x_commit_id_i, x_commit_kill_i,
        input  acc_valid_o, acc_ctl_o, acc_op_a_o, acc_op_b_o, acc_tag_o,
        output acc_ready_i,
        output acc_res_valid_i, acc_res_data_i, acc_res_tag_i,
        input  acc_res_ready_o,
        input  x_result_valid_o, x_result_id_o, x_result_rd_o, x_result_data_o,
               x_result_we_o,
        output x_result_ready_i,
        input  busy_o
    );
endinterface

// File: rtl/dummy_accelerator_ctl.sv
// Purpose : X-IF sequencer for the dummy accelerator datapath. Decodes an
//           offloaded instruction, waits for its commit/kill, dispatches
//           ctl + operands + {id, rd} tag to the datapath and returns the
//           datapath result on the X-IF result bus. One instruction in flight.
// Ports   : clk_i  clock
//           rst_i  synchronous active-high reset
//           bus    dummy_accelerator_ctl_if.slave (issue, commit, datapath
//                  request/response, result, busy)
//           perf_accepted_o / perf_killed_o  32-bit event counters, present
//                  only when DUMMY_ACC_CTL_PERF_EN is defined
// Config  : DUMMY_ACC_CTL_PERF_EN - enables the performance counters.
module dummy_accelerator_ctl (
    input  logic                    clk_i,
    input  logic                    rst_i,
    dummy_accelerator_ctl_if.slave  bus
`ifdef DUMMY_ACC_CTL_PERF_EN
    ,
    output logic [31:0]             perf_accepted_o,
    output logic [31:0]             perf_killed_o
`endif
);
    localparam int unsigned XLEN       = 32;
    localparam int unsigned X_ID_WIDTH = 4;
    localparam int unsigned IMM_WIDTH  = 12;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned TAG_W      = X_ID_WIDTH + ADDR_WIDTH;

    localparam logic [6:0] ACC_OPCODE = 7'b1110111;
    localparam logic [2:0] ACC_FUNCT3 = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_COMMIT,
        S_EXEC,
        S_WAIT_RES,
        S_RESULT
    } state_e;

    state_e                 state_q, state_d;
    logic [X_ID_WIDTH-1:0]  id_q, id_d;
    logic [ADDR_WIDTH-1:0]  rd_q, rd_d;
    logic [IMM_WIDTH-1:0]   ctl_q, ctl_d;
    logic [XLEN-1:0]        op_a_q, op_a_d;
    logic [XLEN-1:0]        op_b_q, op_b_d;
    logic [XLEN-1:0]        res_data_q, res_data_d;
    logic [TAG_W-1:0]       res_tag_q, res_tag_d;
    logic                   res_we_q, res_we_d;
    logic                   acc_valid_q, acc_valid_d;
    logic                   res_ready_q, res_ready_d;
    logic                   result_valid_q, result_valid_d;
    logic                   busy_q, busy_d;

    logic match;
    logic is_idle;
    logic issue_ready;
    logic issue_fire;
    logic commit_issue;
    logic commit_held;
    logic accept_evt;
    logic kill_evt;

    // rs1 index field is not needed: operands arrive already read
    logic unused_instr_bits;
    assign unused_instr_bits = ^bus.x_issue_instr_i[19:15];

    // Issue decode and commit matching
    always_comb begin
        match        = (bus.x_issue_instr_i[6:0] == ACC_OPCODE)
                    && (bus.x_issue_instr_i[14:12] == ACC_FUNCT3);
        is_idle      = (state_q == S_IDLE);
        // Non-matching instructions are always handshaked (and rejected);
        // matching ones wait until every operand is valid.
        issue_ready  = is_idle && (!match || (&bus.x_issue_rs_valid_i));
        issue_fire   = bus.x_issue_valid_i && issue_ready && match;
        commit_issue = bus.x_commit_valid_i
                    && (bus.x_commit_id_i == bus.x_issue_id_i);
        commit_held  = bus.x_commit_valid_i && (bus.x_commit_id_i == id_q);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        rd_d       = rd_q;
        ctl_d      = ctl_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        res_data_d = res_data_q;
        res_tag_d  = res_tag_q;
        res_we_d   = res_we_q;
        accept_evt = 1'b0;
        kill_evt   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (issue_fire) begin
                    accept_evt = 1'b1;
                    id_d       = bus.x_issue_id_i;
                    rd_d       = bus.x_issue_instr_i[11:7];
                    ctl_d      = bus.x_issue_instr_i[31:20];
                    op_a_d     = bus.x_issue_rs_i[XLEN-1:0];
                    op_b_d     = bus.x_issue_rs_i[2*XLEN-1:XLEN];
                    // Commit/kill may arrive in the same cycle as the issue
                    if (commit_issue) begin
                        kill_evt = bus.x_commit_kill_i;
                        state_d  = bus.x_commit_kill_i ? S_IDLE : S_EXEC;
                    end else begin
                        state_d  = S_WAIT_COMMIT;
                    end
                end
            end
            S_WAIT_COMMIT: begin
                if (commit_held) begin
                    kill_evt = bus.x_commit_kill_i;
                    state_d  = bus.x_commit_kill_i ? S_IDLE : S_EXEC;
                end
            end
            S_EXEC: begin
                if (bus.acc_ready_i) begin
                    state_d = S_WAIT_RES;
                end
            end
            S_WAIT_RES: begin
                if (bus.acc_res_valid_i) begin
                    res_data_d = bus.acc_res_data_i;
                    res_tag_d  = bus.acc_res_tag_i;
                    res_we_d   = (bus.acc_res_tag_i[ADDR_WIDTH-1:0] != '0);
                    state_d    = S_RESULT;
                end
            end
            S_RESULT: begin
                if (bus.x_result_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake flags are decoded from the next state so they come
        // straight out of flops.
        acc_valid_d    = (state_d == S_EXEC);
        res_ready_d    = (state_d == S_WAIT_RES);
        result_valid_d = (state_d == S_RESULT);
        busy_d         = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            id_q           <= '0;
            rd_q           <= '0;
            ctl_q          <= '0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            res_data_q     <= '0;
            res_tag_q      <= '0;
            res_we_q       <= 1'b0;
            acc_valid_q    <= 1'b0;
            res_ready_q    <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            id_q           <= id_d;
            rd_q           <= rd_d;
            ctl_q          <= ctl_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            res_data_q     <= res_data_d;
            res_tag_q      <= res_tag_d;
            res_we_q       <= res_we_d;
            acc_valid_q    <= acc_valid_d;
            res_ready_q    <= res_ready_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
        end
    end

    // Issue-side outputs depend on the presented instruction, so they are
    // combinational from the decode.
    assign bus.x_issue_ready_o     = issue_ready;
    assign bus.x_issue_accept_o    = is_idle && match;
    assign bus.x_issue_writeback_o = is_idle && match;

    assign bus.acc_valid_o      = acc_valid_q;
    assign bus.acc_ctl_o        = ctl_q;
    assign bus.acc_op_a_o       = op_a_q;
    assign bus.acc_op_b_o       = op_b_q;
    assign bus.acc_tag_o        = {id_q, rd_q};
    assign bus.acc_res_ready_o  = res_ready_q;

    assign bus.x_result_valid_o = result_valid_q;
    assign bus.x_result_id_o    = res_tag_q[TAG_W-1:ADDR_WIDTH];
    assign bus.x_result_rd_o    = res_tag_q[ADDR_WIDTH-1:0];
    assign bus.x_result_data_o  = res_data_q;
    assign bus.x_result_we_o    = res_we_q;
    assign bus.busy_o           = busy_q;

`ifdef DUMMY_ACC_CTL_PERF_EN
    logic [31:0] perf_acc_q, perf_acc_d;
    logic [31:0] perf_kill_q, perf_kill_d;

    // Free-running event counters, wrapping naturally at 2^32
    always_comb begin
        perf_acc_d  = perf_acc_q + 32'(accept_evt);
        perf_kill_d = perf_kill_q + 32'(kill_evt);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_acc_q  <= '0;
            perf_kill_q <= '0;
        end else begin
            perf_acc_q  <= perf_acc_d;
            perf_kill_q <= perf_kill_d;
        end
    end

    assign perf_accepted_o = perf_acc_q;
    assign perf_killed_o   = perf_kill_q;
`else
    logic unused_perf_evts;
    assign unused_perf_evts = accept_evt ^ kill_evt;
`endif

endmodule

// File: tb/tb_dummy_accelerator_ctl.sv
// Self-checking bench for dummy_accelerator_ctl: directed issue/commit/
// datapath sequences push expected datapath requests and X-IF results into
// queues; a monitor compares them whenever the DUT presents them.
module tb_dummy_accelerator_ctl;
    logic clk;
    logic rst_i;

    dummy_accelerator_ctl_if bus ();

`ifdef DUMMY_ACC_CTL_PERF_EN
    logic [31:0] perf_accepted;
    logic [31:0] perf_killed;
`endif

    dummy_accelerator_ctl dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
`ifdef DUMMY_ACC_CTL_PERF_EN
        ,
        .perf_accepted_o (perf_accepted),
        .perf_killed_o   (perf_killed)
`endif
    );

    typedef struct {
        logic [11:0] ctl;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [8:0]  tag;
    } acc_item_t;

    typedef struct {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
    } res_item_t;

    acc_item_t exp_acc[$];
    res_item_t exp_res[$];

    int n_checks = 0;
    int n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: peek while valid (payload must hold), pop on handshake
    always @(negedge clk) begin
        if (!rst_i) begin
            if (bus.acc_valid_o) begin
                if (exp_acc.size() == 0) begin
                    check("acc_unexpected_valid", 32'(bus.acc_valid_o), 32'd0);
                end else begin
                    check("acc_ctl",  32'(bus.acc_ctl_o),  32'(exp_acc[0].ctl));
                    check("acc_op_a", bus.acc_op_a_o,      exp_acc[0].op_a);
                    check("acc_op_b", bus.acc_op_b_o,      exp_acc[0].op_b);
                    check("acc_tag",  32'(bus.acc_tag_o),  32'(exp_acc[0].tag));
                    if (bus.acc_ready_i) void'(exp_acc.pop_front());
                end
            end
            if (bus.x_result_valid_o) begin
                if (exp_res.size() == 0) begin
                    check("res_unexpected_valid", 32'(bus.x_result_valid_o), 32'd0);
                end else begin
                    check("res_id",   32'(bus.x_result_id_o),  32'(exp_res[0].id));
                    check("res_rd",   32'(bus.x_result_rd_o),  32'(exp_res[0].rd));
                    check("res_data", bus.x_result_data_o,     exp_res[0].data);
                    check("res_we",   32'(bus.x_result_we_o),  32'(exp_res[0].we));
                    if (bus.x_result_ready_i) void'(exp_res.pop_front());
                end
            end
        end
    end

    // Full transaction: issue, commit (same or next cycle), dispatch with
    // acc_stall cycles of backpressure, response, result held res_stall cycles.
    task automatic run_op(input logic [31:0] instr, input logic [3:0] id,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [11:0] exp_ctl, input logic [4:0] exp_rd,
                          input logic [31:0] res, input bit same_commit,
                          input int acc_stall, input int res_stall);
        acc_item_t a;
        res_item_t r;
        a.ctl  = exp_ctl;
        a.op_a = rs1;
        a.op_b = rs2;
        a.tag  = {id, exp_rd};
        exp_acc.push_back(a);

        bus.x_issue_valid_i    = 1'b1;
        bus.x_issue_instr_i    = instr;
        bus.x_issue_id_i       = id;
        bus.x_issue_rs_i       = {rs2, rs1};
        bus.x_issue_rs_valid_i = 2'b11;
        if (same_commit) begin
            bus.x_commit_valid_i = 1'b1;
            bus.x_commit_id_i    = id;
            bus.x_commit_kill_i  = 1'b0;
        end
        #1;
        check("issue_ready", 32'(bus.x_issue_ready_o), 32'd1);
        check("issue_accept", 32'(bus.x_issue_accept_o), 32'd1);
        check("issue_writeback", 32'(bus.x_issue_writeback_o), 32'd1);
        tick();
        bus.x_issue_valid_i  = 1'b0;
        bus.x_commit_valid_i = 1'b0;

        if (!same_commit) begin
            #1;
            check("busy_wait_commit", 32'(bus.busy_o), 32'd1);
            check("no_acc_before_commit", 32'(bus.acc_valid_o), 32'd0);
            check("ready_low_wait_commit", 32'(bus.x_issue_ready_o), 32'd0);
            bus.x_commit_valid_i = 1'b1;
            bus.x_commit_id_i    = id;
            bus.x_commit_kill_i  = 1'b0;
            tick();
            bus.x_commit_valid_i = 1'b0;
        end

        for (int i = 0; i < acc_stall; i++) begin
            #1;
            check("acc_valid_held", 32'(bus.acc_valid_o), 32'd1);
            tick();
        end
        #1;
        check("acc_valid", 32'(bus.acc_valid_o), 32'd1);
        bus.acc_ready_i = 1'b1;
        tick();
        bus.acc_ready_i = 1'b0;

        r.id   = id;
        r.rd   = exp_rd;
        r.data = res;
        r.we   = (exp_rd != 5'd0);
        exp_res.push_back(r);
        #1;
        check("acc_res_ready", 32'(bus.acc_res_ready_o), 32'd1);
        bus.acc_res_valid_i = 1'b1;
        bus.acc_res_data_i  = res;
        bus.acc_res_tag_i   = {id, exp_rd};
        tick();
        bus.acc_res_valid_i = 1'b0;

        for (int i = 0; i < res_stall; i++) begin
            #1;
            check("result_held", 32'(bus.x_result_valid_o), 32'd1);
            check("ready_low_in_result", 32'(bus.x_issue_ready_o), 32'd0);
            tick();
        end
        bus.x_result_ready_i = 1'b1;
        tick();
        bus.x_result_ready_i = 1'b0;
        #1;
        check("busy_after_result", 32'(bus.busy_o), 32'd0);
        check("ready_after_result", 32'(bus.x_issue_ready_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i                  = 1'b1;
        bus.x_issue_valid_i    = 1'b0;
        bus.x_issue_instr_i    = 32'h0;
        bus.x_issue_id_i       = 4'h0;
        bus.x_issue_rs_i       = 64'h0;
        bus.x_issue_rs_valid_i = 2'b11;
        bus.x_commit_valid_i   = 1'b0;
        bus.x_commit_id_i      = 4'h0;
        bus.x_commit_kill_i    = 1'b0;
        bus.acc_ready_i        = 1'b0;
        bus.acc_res_valid_i    = 1'b0;
        bus.acc_res_data_i     = 32'h0;
        bus.acc_res_tag_i      = 9'h0;
        bus.x_result_ready_i   = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        // Reset state
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_acc_valid", 32'(bus.acc_valid_o), 32'd0);
        check("rst_res_ready", 32'(bus.acc_res_ready_o), 32'd0);
        check("rst_result_valid", 32'(bus.x_result_valid_o), 32'd0);
        check("rst_we", 32'(bus.x_result_we_o), 32'd0);
        check("rst_accept", 32'(bus.x_issue_accept_o), 32'd0);
        check("rst_ready", 32'(bus.x_issue_ready_o), 32'd1);
        check("rst_tag", 32'(bus.acc_tag_o), 32'd0);
        tick();

        // Non-matching opcode: handshaked but rejected
        bus.x_issue_valid_i = 1'b1;
        bus.x_issue_instr_i = 32'h0000_0033;
        bus.x_issue_id_i    = 4'd4;
        #1;
        check("nm_ready", 32'(bus.x_issue_ready_o), 32'd1);
        check("nm_accept", 32'(bus.x_issue_accept_o), 32'd0);
        check("nm_writeback", 32'(bus.x_issue_writeback_o), 32'd0);
        tick();
        check("nm_busy", 32'(bus.busy_o), 32'd0);
        // Right opcode, wrong funct3
        bus.x_issue_instr_i = 32'h0000_1077;
        #1;
        check("f3_accept", 32'(bus.x_issue_accept_o), 32'd0);
        tick();
        check("f3_busy", 32'(bus.busy_o), 32'd0);
        // Matching but operand not ready: no handshake
        bus.x_issue_instr_i    = 32'h0012_8077;
        bus.x_issue_rs_valid_i = 2'b01;
        #1;
        check("rsv_ready", 32'(bus.x_issue_ready_o), 32'd0);
        tick();
        check("rsv_busy", 32'(bus.busy_o), 32'd0);
        bus.x_issue_valid_i    = 1'b0;
        bus.x_issue_rs_valid_i = 2'b11;
        tick();

        // rd=0, ctl=1, id=3, 5+7 -> 12, we=0
        run_op(32'h0012_8077, 4'd3, 32'd5, 32'd7, 12'h001, 5'd0, 32'd12, 1'b0, 0, 0);
        // same-cycle commit, rd=5, ctl=0xABC, backpressure on both sides
        run_op(32'hABC1_02F7, 4'd1, 32'h1111_1111, 32'h2222_2222, 12'hABC, 5'd5,
               32'h3333_3333, 1'b1, 3, 4);

        // Same-cycle kill: never leaves IDLE
        bus.x_issue_valid_i  = 1'b1;
        bus.x_issue_instr_i  = 32'h0012_8077;
        bus.x_issue_id_i     = 4'd6;
        bus.x_commit_valid_i = 1'b1;
        bus.x_commit_id_i    = 4'd6;
        bus.x_commit_kill_i  = 1'b1;
        #1;
        check("sk_accept", 32'(bus.x_issue_accept_o), 32'd1);
        tick();
        bus.x_issue_valid_i  = 1'b0;
        bus.x_commit_valid_i = 1'b0;
        bus.x_commit_kill_i  = 1'b0;
        #1;
        check("sk_busy", 32'(bus.busy_o), 32'd0);
        check("sk_acc_valid", 32'(bus.acc_valid_o), 32'd0);
        tick();

        // Reset while waiting for the datapath response
        begin
            acc_item_t a;
            a.ctl = 12'h001; a.op_a = 32'd9; a.op_b = 32'd10; a.tag = {4'd7, 5'd0};
            exp_acc.push_back(a);
        end
        bus.x_issue_valid_i  = 1'b1;
        bus.x_issue_instr_i  = 32'h0012_8077;
        bus.x_issue_id_i     = 4'd7;
        bus.x_issue_rs_i     = {32'd10, 32'd9};
        bus.x_commit_valid_i = 1'b1;
        bus.x_commit_id_i    = 4'd7;
        tick();
        bus.x_issue_valid_i  = 1'b0;
        bus.x_commit_valid_i = 1'b0;
        bus.acc_ready_i      = 1'b1;
        tick();
        bus.acc_ready_i = 1'b0;
        #1;
        check("rm_res_ready", 32'(bus.acc_res_ready_o), 32'd1);
        bus.acc_res_valid_i = 1'b1;
        bus.acc_res_data_i  = 32'hDEAD_BEEF;
        bus.acc_res_tag_i   = {4'd7, 5'd3};
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        check("rm_busy", 32'(bus.busy_o), 32'd0);
        check("rm_res_ready_low", 32'(bus.acc_res_ready_o), 32'd0);
        check("rm_result_valid", 32'(bus.x_result_valid_o), 32'd0);
        check("rm_acc_valid", 32'(bus.acc_valid_o), 32'd0);
        check("rm_we", 32'(bus.x_result_we_o), 32'd0);
        check("rm_data", bus.x_result_data_o, 32'd0);
        check("rm_ready", 32'(bus.x_issue_ready_o), 32'd1);
        tick();
        // Pending response must not be consumed after the abort
        check("rm_still_idle", 32'(bus.busy_o), 32'd0);
        check("rm_res_ready_idle", 32'(bus.acc_res_ready_o), 32'd0);
        bus.acc_res_valid_i = 1'b0;
        tick();

        // Accept id5, foreign commit id2 ignored, kill id5
        bus.x_issue_valid_i = 1'b1;
        bus.x_issue_instr_i = 32'h0012_8077;
        bus.x_issue_id_i    = 4'd5;
        tick();
        bus.x_issue_valid_i  = 1'b0;
        bus.x_commit_valid_i = 1'b1;
        bus.x_commit_id_i    = 4'd2;
        bus.x_commit_kill_i  = 1'b0;
        #1;
        check("kt_busy", 32'(bus.busy_o), 32'd1);
        tick();
        bus.x_commit_id_i   = 4'd5;
        bus.x_commit_kill_i = 1'b1;
        #1;
        check("kt_ignored_busy", 32'(bus.busy_o), 32'd1);
        check("kt_no_acc", 32'(bus.acc_valid_o), 32'd0);
        tick();
        bus.x_commit_valid_i = 1'b0;
        bus.x_commit_kill_i  = 1'b0;
        #1;
        check("kt_idle", 32'(bus.busy_o), 32'd0);
        check("kt_no_acc_after", 32'(bus.acc_valid_o), 32'd0);
        check("kt_ready", 32'(bus.x_issue_ready_o), 32'd1);
        tick();

        // rd=31 (we=1), ctl=0xFFF, id=15, all-ones operand
        run_op(32'hFFF0_0FF7, 4'd15, 32'hFFFF_FFFF, 32'd1, 12'hFFF, 5'd31,
               32'd0, 1'b0, 1, 0);
        run_op(32'h0012_8077, 4'd2, 32'd100, 32'd23, 12'h001, 5'd0,
               32'd123, 1'b1, 0, 2);

`ifdef DUMMY_ACC_CTL_PERF_EN
        // Since the mid-op reset: kill test + two ops accepted, one kill
        check("perf_accepted", perf_accepted, 32'd3);
        check("perf_killed", perf_killed, 32'd1);
`endif
        tick();
        check("acc_queue_drained", 32'(exp_acc.size()), 32'd0);
        check("res_queue_drained", 32'(exp_res.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
